chan_est_weight_manager: RTL and testbench

CHAN_EST_WEIGHT_MANAGER -- requirements
Module: chan_est_weight_manager

---
 rtl/channel_gpack.sv | 20 ++
 rtl/const_pack.sv | 4 +
 rtl/wme_debug_intf.sv | 16 +
 rtl/wme_inst_decode.sv | 15 +
 rtl/chan_est_weight_manager.sv | 125 ++++++++++++
 tb/tb_chan_est_weight_manager.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/channel_gpack.sv
// Channel-estimate sizes, debug instruction layout and shared types for the weight manager.
package channel_gpack;
    localparam int est_channel_depth     = 6;
    localparam int est_channel_precision = 12;

    localparam int WME_LANE_W   = $clog2(const_pack::Nti);
    localparam int WME_TAP_W    = $clog2(est_channel_depth);
    localparam int WME_TAP_OFS  = 0;
    localparam int WME_LANE_OFS = WME_TAP_OFS + WME_TAP_W;
    localparam int WME_OP_OFS   = WME_LANE_OFS + WME_LANE_W;
    localparam int WME_INST_W   = WME_OP_OFS + 1;
    localparam int WME_DATA_W   = 32;

    typedef enum logic {WME_RD = 1'b0, WME_WR = 1'b1} wme_op_e;
    typedef enum logic [1:0] {WME_IDLE, WME_EXEC, WME_WAIT_LOW} wme_state_e;

    function automatic logic in_range(input int idx, input int lim);
        return (idx >= 0) && (idx < lim);
    endfunction
endpackage

// File: rtl/const_pack.sv
// Global system constants shared across the receiver.
package const_pack;
    localparam int Nti = 4;
endpackage

// File: rtl/wme_debug_intf.sv
// JTAG-side debug access to the channel-estimate weight array.
interface wme_debug_intf;
    import channel_gpack::*;

    logic [WME_DATA_W-1:0]                   wme_chan_data;
    logic [WME_INST_W-1:0]                   wme_chan_inst;
    logic                                    wme_chan_exec;
    logic signed [est_channel_precision-1:0] wme_chan_read;

    modport wme (
        input  wme_chan_data,
        input  wme_chan_inst,
        input  wme_chan_exec,
        output wme_chan_read
    );
endinterface

// File: rtl/wme_inst_decode.sv
// Splits a debug instruction into op/lane/tap and flags addresses outside the array.
module wme_inst_decode
    import channel_gpack::*;
(
    input  logic [WME_INST_W-1:0] inst,
    output logic                  op,
    output logic [WME_LANE_W-1:0] lane,
    output logic [WME_TAP_W-1:0]  tap,
    output logic                  valid
);
    assign op    = inst[WME_OP_OFS];
    assign lane  = inst[WME_LANE_OFS +: WME_LANE_W];
    assign tap   = inst[WME_TAP_OFS +: WME_TAP_W];
    assign valid = in_range(int'(lane), const_pack::Nti) && in_range(int'(tap), est_channel_depth);
endmodule

// File: rtl/chan_est_weight_manager.sv
// Channel-estimate weight store: datapath adaptation port plus a JTAG debug read/write FSM.
module chan_est_weight_manager
    import channel_gpack::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    wme_debug_intf.wme                              dbg_intf,
    input  logic                                    upd_en,
    input  logic [WME_LANE_W-1:0]                   upd_lane,
    input  logic [WME_TAP_W-1:0]                    upd_tap,
    input  logic signed [est_channel_precision-1:0] upd_data,
    output logic signed [est_channel_precision-1:0] chan_est [const_pack::Nti][est_channel_depth],
    output logic                                    busy
);
    localparam int NT    = const_pack::Nti;
    localparam int D     = est_channel_depth;
    localparam int P     = est_channel_precision;
    localparam int N_ENT = NT * D;

    wme_state_e              state_q, state_d;
    logic [WME_INST_W-1:0]   inst_q, inst_d;
    logic signed [P-1:0]     data_q, data_d;
    logic signed [P-1:0]     read_q, read_d;
    logic signed [P-1:0]     est_q [NT][D];
    logic signed [P-1:0]     est_d [NT][D];
    logic signed [P-1:0]     rd_val;

    logic                    dec_op;
    logic [WME_LANE_W-1:0]   dec_lane;
    logic [WME_TAP_W-1:0]    dec_tap;
    logic                    dec_valid;
    logic                    dbg_wr_en;
    logic                    dbg_rd_en;
    logic [N_ENT-1:0]        upd_hit;
    logic [N_ENT-1:0]        dbg_hit;
    logic                    unused_data_bits;

    wme_inst_decode u_decode (
        .inst  (inst_q),
        .op    (dec_op),
        .lane  (dec_lane),
        .tap   (dec_tap),
        .valid (dec_valid)
    );

    assign dbg_wr_en = (state_q == WME_EXEC) && (dec_op == WME_WR) && dec_valid;
    assign dbg_rd_en = (state_q == WME_EXEC) && (dec_op == WME_RD);

    // An out-of-range address matches no entry, so both ports ignore it naturally.
    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_entry
        assign upd_hit[gi] = upd_en && (upd_lane == WME_LANE_W'(gi / D))
                                    && (upd_tap == WME_TAP_W'(gi % D));
        assign dbg_hit[gi] = (dec_lane == WME_LANE_W'(gi / D)) && (dec_tap == WME_TAP_W'(gi % D));
        assign chan_est[gi / D][gi % D] = est_q[gi / D][gi % D];
    end

    // Debug write is applied last so it overrides a same-entry adaptation update.
    always_comb begin
        for (int l = 0; l < NT; l++) begin
            for (int t = 0; t < D; t++) begin
                est_d[l][t] = est_q[l][t];
                if (upd_hit[l*D + t]) est_d[l][t] = upd_data;
                if (dbg_wr_en && dbg_hit[l*D + t]) est_d[l][t] = data_q;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int l = 0; l < NT; l++) begin
            for (int t = 0; t < D; t++) begin
                if (dbg_hit[l*D + t]) rd_val = est_q[l][t];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        data_d  = data_q;
        read_d  = read_q;
        case (state_q)
            WME_IDLE: begin
                if (dbg_intf.wme_chan_exec) begin
                    state_d = WME_EXEC;
                    inst_d  = dbg_intf.wme_chan_inst;
                    data_d  = dbg_intf.wme_chan_data[P-1:0];
                end
            end
            WME_EXEC: begin
                state_d = WME_WAIT_LOW;
                if (dbg_rd_en) read_d = dec_valid ? rd_val : '0;
            end
            WME_WAIT_LOW: begin
                if (!dbg_intf.wme_chan_exec) state_d = WME_IDLE;
            end
            default: state_d = WME_WAIT_LOW;
        endcase
    end

    // Reset lands in WAIT_LOW so an exec level held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WME_WAIT_LOW;
            inst_q  <= '0;
            data_q  <= '0;
            read_q  <= '0;
            for (int l = 0; l < NT; l++) begin
                for (int t = 0; t < D; t++) begin
                    est_q[l][t] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            read_q  <= read_d;
            est_q   <= est_d;
        end
    end

    assign dbg_intf.wme_chan_read = read_q;
    assign busy                   = (state_q != WME_IDLE);
    assign unused_data_bits       = ^dbg_intf.wme_chan_data[WME_DATA_W-1:P];
endmodule

// File: tb/tb_chan_est_weight_manager.sv
// Directed self-checking bench for chan_est_weight_manager (Nti=4, D=6, P=12).
module tb_chan_est_weight_manager;
    logic               clk;
    logic               rst;
    logic               upd_en;
    logic [1:0]         upd_lane;
    logic [2:0]         upd_tap;
    logic signed [11:0] upd_data;
    logic signed [11:0] chan_est [4][6];
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_est [4][6];

    wme_debug_intf dbg ();

    chan_est_weight_manager dut (
        .clk      (clk),
        .rst      (rst),
        .dbg_intf (dbg),
        .upd_en   (upd_en),
        .upd_lane (upd_lane),
        .upd_tap  (upd_tap),
        .upd_data (upd_data),
        .chan_est (chan_est),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic check_all(input string tag);
        for (int l = 0; l < 4; l++) begin
            for (int t = 0; t < 6; t++) begin
                chk($sformatf("%s[%0d][%0d]", tag, l, t), chan_est[l][t], exp_est[l][t]);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dbg(input bit wr, input int lane, input int tap, input logic [31:0] data);
        logic [1:0] ln;
        logic [2:0] tp;
        ln = lane[1:0];
        tp = tap[2:0];
        dbg.wme_chan_inst = {wr, ln, tp};
        dbg.wme_chan_data = data;
        dbg.wme_chan_exec = 1'b1;
        $display("dbg %s lane=%0d tap=%0d data=0x%08h", wr ? "WR" : "RD", lane, tap, data);
    endtask

    task automatic drop_exec(input string tag);
        dbg.wme_chan_exec = 1'b0;
        tick(1);
        chk(tag, busy, 0);
    endtask

    task automatic upd(input int lane, input int tap, input int val);
        logic [1:0] ln;
        logic [2:0] tp;
        ln = lane[1:0];
        tp = tap[2:0];
        upd_en   = 1'b1;
        upd_lane = ln;
        upd_tap  = tp;
        upd_data = 12'(val);
        $display("upd lane=%0d tap=%0d data=%0d", lane, tap, val);
    endtask

    initial begin
        for (int l = 0; l < 4; l++)
            for (int t = 0; t < 6; t++)
                exp_est[l][t] = 0;
        rst = 1'b1;
        upd_en = 1'b0; upd_lane = '0; upd_tap = '0; upd_data = '0;
        set_dbg(1, 0, 0, 32'h77);
        tick(3);
        rst = 1'b0;
        check_all("rst");
        chk("rst_read", dbg.wme_chan_read, 0);
        chk("rst_busy", busy, 1);
        tick(3);
        chk("rst_hold_busy", busy, 1);
        check_all("rst_hold");
        drop_exec("rst_busy_clr");

        // Debug write held 10 cycles: only one write may happen.
        set_dbg(1, 3, 5, 32'hABCD_E1A5);
        tick(1);
        chk("wr_early", chan_est[3][5], 0);
        chk("wr_busy", busy, 1);
        tick(1);
        exp_est[3][5] = 'h1A5;
        check_all("wr");
        tick(2);
        upd(3, 5, 'h022);
        tick(1);
        upd_en = 1'b0;
        exp_est[3][5] = 'h022;
        chk("upd_any_state", chan_est[3][5], 'h022);
        tick(5);
        chk("one_wr", chan_est[3][5], 'h022);
        drop_exec("wr_busy_clr");
        upd(3, 5, 'h1A5);
        tick(1);
        upd_en = 1'b0;
        exp_est[3][5] = 'h1A5;
        chk("upd_restore", chan_est[3][5], 'h1A5);

        set_dbg(0, 3, 5, 32'h0);
        tick(1);
        chk("rd_early", dbg.wme_chan_read, 0);
        tick(1);
        chk("rd", dbg.wme_chan_read, 'h1A5);
        drop_exec("rd_busy_clr");
        tick(3);
        chk("rd_held", dbg.wme_chan_read, 'h1A5);

        set_dbg(1, 1, 2, 32'h0000_0800);
        tick(2);
        exp_est[1][2] = -2048;
        chk("wr_neg", chan_est[1][2], -2048);
        drop_exec("neg_busy_clr");

        // Same-entry conflict: debug write beats the update.
        set_dbg(1, 0, 0, 32'h7);
        tick(1);
        upd(0, 0, -4);
        tick(1);
        upd_en = 1'b0;
        exp_est[0][0] = 7;
        check_all("conflict_same");
        drop_exec("conflict_busy_clr");
        upd(0, 0, 0);
        tick(1);
        upd_en = 1'b0;
        exp_est[0][0] = 0;
        chk("conflict_clear", chan_est[0][0], 0);
        set_dbg(1, 0, 0, 32'h7);
        tick(1);
        upd(0, 1, -4);
        tick(1);
        upd_en = 1'b0;
        exp_est[0][0] = 7;
        exp_est[0][1] = -4;
        check_all("conflict_diff");
        drop_exec("diff_busy_clr");

        set_dbg(0, 0, 0, 32'h0);
        tick(1);
        upd(0, 0, -4);
        tick(1);
        upd_en = 1'b0;
        exp_est[0][0] = -4;
        chk("rd_pre_upd", dbg.wme_chan_read, 7);
        check_all("rd_upd");
        drop_exec("rdupd_busy_clr");

        // Out-of-range addresses.
        set_dbg(1, 2, 6, 32'h55);
        tick(2);
        check_all("oor_wr");
        drop_exec("oor_wr_busy_clr");
        set_dbg(0, 2, 6, 32'h0);
        tick(2);
        chk("oor_rd", dbg.wme_chan_read, 0);
        drop_exec("oor_rd_busy_clr");
        upd(2, 7, 'h55);
        tick(1);
        upd_en = 1'b0;
        check_all("oor_upd");

        // Reset during EXEC of a write, with a competing update.
        set_dbg(1, 2, 4, 32'h123);
        tick(1);
        rst = 1'b1;
        upd(1, 1, 3);
        tick(1);
        rst = 1'b0;
        upd_en = 1'b0;
        for (int l = 0; l < 4; l++)
            for (int t = 0; t < 6; t++)
                exp_est[l][t] = 0;
        check_all("rst_mid");
        chk("rst_mid_read", dbg.wme_chan_read, 0);
        chk("rst_mid_busy", busy, 1);
        tick(3);
        chk("rst_mid_hold_busy", busy, 1);
        chk("rst_mid_hold", chan_est[2][4], 0);
        drop_exec("rst_mid_busy_clr");
        set_dbg(1, 2, 4, 32'h123);
        tick(2);
        exp_est[2][4] = 'h123;
        check_all("rearm");
        drop_exec("rearm_busy_clr");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
